// File: rtl/mem_arbiter_if.sv
// Two CPU request ports plus the byte-wide memory bus, grouped for the arbiter.
// The slave view is the arbiter; the master view is its environment (requesters and memory).
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    localparam int WORD_WIDTH = 2 * DATA_WIDTH;

    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic                  word0;
    logic                  word1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [WORD_WIDTH-1:0] wdata0;
    logic [WORD_WIDTH-1:0] wdata1;
    logic                  done0;
    logic                  done1;
    logic [WORD_WIDTH-1:0] rdata0;
    logic [WORD_WIDTH-1:0] rdata1;
    logic                  memWrite;
    logic [ADDR_WIDTH-1:0] memAddress;
    logic [DATA_WIDTH-1:0] memValue;
    logic [DATA_WIDTH-1:0] memReadValue;

    modport master (
        output req0, req1, we0, we1, word0, word1, addr0, addr1, wdata0, wdata1,
        input  done0, done1, rdata0, rdata1,
        input  memWrite, memAddress, memValue,
        output memReadValue
    );

    modport slave (
        input  req0, req1, we0, we1, word0, word1, addr0, addr1, wdata0, wdata1,
        output done0, done1, rdata0, rdata1,
        output memWrite, memAddress, memValue,
        input  memReadValue
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction-fetch (port 0) and load/store (port 1) for the
// single-port byte memory; 16-bit accesses are split into two big-endian byte accesses.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    localparam int WORD_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        XFER0,
        XFER1,
        CAPTURE,
        RESP
    } state_t;

    state_t                state;
    state_t                stateNext;
    logic                  grant;
    logic                  grantNext;
    logic                  lastGrant;
    logic                  lastGrantNext;
    logic [ADDR_WIDTH-1:0] addrLat;
    logic [ADDR_WIDTH-1:0] addrLatNext;
    logic                  weLat;
    logic                  weLatNext;
    logic                  wordLat;
    logic                  wordLatNext;
    logic [WORD_WIDTH-1:0] wdataLat;
    logic [WORD_WIDTH-1:0] wdataLatNext;
    logic [DATA_WIDTH-1:0] hiByte;
    logic [DATA_WIDTH-1:0] hiByteNext;

    logic                  memWriteNext;
    logic [ADDR_WIDTH-1:0] memAddressNext;
    logic [DATA_WIDTH-1:0] memValueNext;
    logic                  done0Next;
    logic                  done1Next;
    logic [WORD_WIDTH-1:0] rdata0Next;
    logic [WORD_WIDTH-1:0] rdata1Next;

    logic                  selPort;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic                  selWe;
    logic                  selWord;
    logic [WORD_WIDTH-1:0] selWdata;
    logic [WORD_WIDTH-1:0] readWord;

    // On a tie the port that did not win last time is chosen.
    assign selPort  = (bus.req0 && bus.req1) ? ~lastGrant : bus.req1;
    assign selAddr  = selPort ? bus.addr1  : bus.addr0;
    assign selWe    = selPort ? bus.we1    : bus.we0;
    assign selWord  = selPort ? bus.word1  : bus.word0;
    assign selWdata = selPort ? bus.wdata1 : bus.wdata0;

    // The high byte of a word read is parked in hiByte so rdata only changes at completion.
    assign readWord = {wordLat ? hiByte : {DATA_WIDTH{1'b0}}, bus.memReadValue};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            grant          <= 1'b0;
            lastGrant      <= 1'b1;
            addrLat        <= '0;
            weLat          <= 1'b0;
            wordLat        <= 1'b0;
            wdataLat       <= '0;
            hiByte         <= '0;
            bus.memWrite   <= 1'b0;
            bus.memAddress <= '0;
            bus.memValue   <= '0;
            bus.done0      <= 1'b0;
            bus.done1      <= 1'b0;
            bus.rdata0     <= '0;
            bus.rdata1     <= '0;
        end else begin
            state          <= stateNext;
            grant          <= grantNext;
            lastGrant      <= lastGrantNext;
            addrLat        <= addrLatNext;
            weLat          <= weLatNext;
            wordLat        <= wordLatNext;
            wdataLat       <= wdataLatNext;
            hiByte         <= hiByteNext;
            bus.memWrite   <= memWriteNext;
            bus.memAddress <= memAddressNext;
            bus.memValue   <= memValueNext;
            bus.done0      <= done0Next;
            bus.done1      <= done1Next;
            bus.rdata0     <= rdata0Next;
            bus.rdata1     <= rdata1Next;
        end
    end

    // Outputs are registered, so each branch computes what the bus shows in the state being entered.
    always_comb begin
        stateNext      = state;
        grantNext      = grant;
        lastGrantNext  = lastGrant;
        addrLatNext    = addrLat;
        weLatNext      = weLat;
        wordLatNext    = wordLat;
        wdataLatNext   = wdataLat;
        hiByteNext     = hiByte;
        memWriteNext   = 1'b0;
        memAddressNext = bus.memAddress;
        memValueNext   = bus.memValue;
        rdata0Next     = bus.rdata0;
        rdata1Next     = bus.rdata1;

        unique case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    stateNext      = XFER0;
                    grantNext      = selPort;
                    addrLatNext    = selAddr;
                    weLatNext      = selWe;
                    wordLatNext    = selWord;
                    wdataLatNext   = selWdata;
                    memAddressNext = selAddr;
                    if (selWe) begin
                        memWriteNext = 1'b1;
                        memValueNext = selWord ? selWdata[WORD_WIDTH-1:DATA_WIDTH]
                                               : selWdata[DATA_WIDTH-1:0];
                    end
                end
            end
            XFER0: begin
                if (wordLat) begin
                    stateNext      = XFER1;
                    memAddressNext = addrLat + ADDR_WIDTH'(1);
                    if (weLat) begin
                        memWriteNext = 1'b1;
                        memValueNext = wdataLat[DATA_WIDTH-1:0];
                    end
                end else begin
                    stateNext = weLat ? RESP : CAPTURE;
                end
            end
            XFER1: begin
                if (weLat) begin
                    stateNext = RESP;
                end else begin
                    hiByteNext = bus.memReadValue;
                    stateNext  = CAPTURE;
                end
            end
            CAPTURE: begin
                stateNext = RESP;
                if (grant) rdata1Next = readWord;
                else       rdata0Next = readWord;
            end
            RESP: begin
                stateNext     = IDLE;
                lastGrantNext = grant;
            end
            default: stateNext = IDLE;
        endcase

        done0Next = (stateNext == RESP) && !grantNext;
        done1Next = (stateNext == RESP) && grantNext;
    end
endmodule
